n_bit_subtractor: RTL and testbench
===================================

Name: n_bit_subtractor

Overview:
- Parameterised N-bit two's-complement subtractor: result = a + (~b) + 1, truncated to N bits.
- Registered output stage with valid tagging.
- Also produces unsigned borrow, signed overflow, zero and negative flags.
- Used as a datapath arithmetic leaf, e.g. ALU subtract path or comparator front end, wherever a one-cycle registered difference is needed.

Parameters:
- N, default 4, operand and result width in bits. Must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  N  minuend.
- b  input  N  subtrahend.
- result  output  N  registered difference a - b, modulo 2^N.
- borrow  output  1  registered unsigned borrow: 1 when a < b unsigned (inverted carry-out of a + ~b + 1).
- overflow  output  1  registered signed overflow: 1 when sign(a) != sign(b) and sign(result) != sign(a).
- zero  output  1  registered: result == 0.
- negative  output  1  registered: result[N-1].
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Datapath structure:
  - Combinational core is a ripple chain of N full adders.
  - Operand A = a, operand B = ~b, carry-in = 1.
  - carry-out c_N; borrow = ~c_N.
  - Overflow = c_N-1 XOR c_N.
- Capture rule:
  - On each rising clk edge with in_valid=1, result and all flags capture the core outputs.
  - out_valid <= 1 on that edge.
- Idle rule:
  - On a rising edge with in_valid=0, out_valid <= 0.
  - result and flags hold their previous values; no enable glitching.
- Latency: exactly 1 cycle from in_valid/operands to out_valid/result. Throughput is one operation per cycle; back-to-back valids are allowed.
- Reset:
  - rst_n low asynchronously clears result, borrow, overflow, negative and out_valid to 0.
  - zero is cleared to 1, consistent with result=0.
  - Reset asserted mid-stream discards any in-flight operation.
  - After rst_n deasserts, the first capture happens on the first edge with in_valid=1.
- Arithmetic: wrap-around modulo 2^N; no saturation.
  - a == b gives result 0, borrow 0, zero 1.
  - b = 0 gives result a, borrow 0, overflow 0.
  - a = 0, b = 1 gives all-ones, borrow 1, negative 1.
  - Most-negative minus 1 (e.g. 1000 - 0001 = 0111) gives overflow 1.
- No X-propagation requirements: while in_valid=0, operand values are don't-care.

Test Plan:
- Reset then idle: hold rst_n=0, then release with in_valid=0 -> out_valid=0, result=0000, zero=1, other flags 0.
- a=1010, b=0011, in_valid=1 -> next cycle result=0111, borrow=0, overflow=1, negative=0, zero=0, out_valid=1.
- a=0100, b=1000 -> result=1100, borrow=1, overflow=1, negative=1.
- Back-to-back inputs:
  - Cycle 1: a=1010, b=1111 -> result=1011, borrow=1, overflow=0.
  - Cycle 2: a=1101, b=1111 -> result=1110, borrow=1, overflow=0.
  - out_valid stays 1 for both cycles.
- a=0110, b=0110 -> result=0000, zero=1, borrow=0. Then an in_valid=0 cycle -> out_valid=0 with result held at 0000.
- Drop rst_n asynchronously between clock edges while out_valid=1 -> outputs clear immediately without waiting for a clk edge.
- N=8 instance: a=0x00, b=0x01 -> result=0xFF, borrow=1, negative=1, overflow=0.

Source files
------------

// File: rtl/n_bit_subtractor.sv
// rtl/n_bit_subtractor.sv - registered N-bit two's-complement subtractor with status flags
//
// Purpose:
//   Computes a - b as a + ~b + 1 through a ripple chain of full adders.
//   Registers the difference together with borrow, overflow, zero and
//   negative flags. Latency is one cycle and one operation can be accepted
//   every cycle.
//
// Parameters:
//   N         operand/result width in bits (N >= 2)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   a/b carry a valid operation this cycle
//   a         in   [N-1:0] minuend
//   b         in   [N-1:0] subtrahend
//   result    out  [N-1:0] registered a - b modulo 2^N
//   borrow    out  registered unsigned borrow (a < b)
//   overflow  out  registered signed overflow
//   zero      out  registered result == 0
//   negative  out  registered result[N-1]
//   out_valid out  registered copy of in_valid

// One bit of the ripple chain.
module n_bit_subtractor_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module n_bit_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         borrow,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         out_valid
);

  // ---------------------------------------------------------------------
  // Combinational core: a + ~b + 1
  // ---------------------------------------------------------------------
  logic [N-1:0] b_inv;
  logic [N:0]   carry;
  logic [N-1:0] diff;

  logic         borrow_c;
  logic         overflow_c;
  logic         zero_c;
  logic         negative_c;

  assign b_inv    = ~b;
  // The +1 of the two's-complement negation enters as the chain's carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    n_bit_subtractor_fa u_fa (
      .a_i (a[i]),
      .b_i (b_inv[i]),
      .c_i (carry[i]),
      .s_o (diff[i]),
      .c_o (carry[i+1])
    );
  end

  // A missing carry-out means the unsigned subtraction had to borrow.
  assign borrow_c   = ~carry[N];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign overflow_c = carry[N-1] ^ carry[N];
  assign zero_c     = (diff == '0);
  assign negative_c = diff[N-1];

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  logic [N-1:0] result_d,   result_q;
  logic         borrow_d,   borrow_q;
  logic         overflow_d, overflow_q;
  logic         zero_d,     zero_q;
  logic         negative_d, negative_q;
  logic         valid_d,    valid_q;

  // Data and flags only move on a valid cycle; out_valid tracks in_valid
  // every cycle so idle cycles drop it while the last result stays visible.
  always_comb begin
    result_d   = result_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    valid_d    = in_valid;
    if (in_valid) begin
      result_d   = diff;
      borrow_d   = borrow_c;
      overflow_d = overflow_c;
      zero_d     = zero_c;
      negative_d = negative_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      // Reset result is 0, so the zero flag starts set.
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      valid_q    <= valid_d;
    end
  end

  assign result    = result_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_n_bit_subtractor.sv
// tb/tb_n_bit_subtractor.sv - self-checking bench for n_bit_subtractor (N=4 and N=8)
module tb_n_bit_subtractor;

  logic       clk;
  logic       rst_n;

  logic       in_valid4;
  logic [3:0] a4, b4, result4;
  logic       borrow4, overflow4, zero4, negative4, out_valid4;

  logic       in_valid8;
  logic [7:0] a8, b8, result8;
  logic       borrow8, overflow8, zero8, negative8, out_valid8;

  int n_checks;
  int n_fail;

  n_bit_subtractor #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .a         (a4),
    .b         (b4),
    .result    (result4),
    .borrow    (borrow4),
    .overflow  (overflow4),
    .zero      (zero4),
    .negative  (negative4),
    .out_valid (out_valid4)
  );

  n_bit_subtractor #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .result    (result8),
    .borrow    (borrow8),
    .overflow  (overflow8),
    .zero      (zero8),
    .negative  (negative8),
    .out_valid (out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {result[7:0], borrow, overflow, zero, negative, out_valid}
  localparam logic [12:0] RST_STATE = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [12:0] obs4();
    return {4'b0000, result4, borrow4, overflow4, zero4, negative4, out_valid4};
  endfunction

  function automatic logic [12:0] obs8();
    return {result8, borrow8, overflow8, zero8, negative8, out_valid8};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [12:0] model(int w, int ua, int ub);
    int       full, half, d, sa, sb, sd;
    logic [7:0] r;
    logic     ovf;
    full = 1 << w;
    half = 1 << (w - 1);
    d    = (ua - ub + full) % full;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sd   = sa - sb;
    ovf  = (sd >= half) || (sd < -half);
    r    = d[7:0];
    return {r, (ua < ub), ovf, (d == 0), (d >= half), 1'b1};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual {res,bor,ovf,z,neg,vld}=%h/%b required=%h/%b",
               name, act[12:5], act[4:0], exp[12:5], exp[4:0]);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic [3:0] r;
    logic       bo;
    logic       ov;
    logic       z;
    logic       ng;
    logic       vo;
  } vec_t;

  vec_t tbl[9];

  logic [12:0] mdl4, mdl8, nxt;

  initial begin
    //           a        b        v     r        bo    ov    z     ng    vo
    tbl[0] = '{4'b1010, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{4'b0100, 4'b1000, 1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{4'b1010, 4'b1111, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{4'b1101, 4'b1111, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'b0101, 4'b0000, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid4 = 1'b0;
    a4        = '0;
    b4        = '0;
    in_valid8 = 1'b0;
    a8        = '0;
    b8        = '0;

    // Reset held, then released with no valid input.
    repeat (3) @(negedge clk);
    check("reset_hold4", obs4(), RST_STATE);
    check("reset_hold8", obs8(), RST_STATE);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle4", obs4(), RST_STATE);
    check("reset_idle8", obs8(), RST_STATE);

    // Directed table, applied back to back.
    a4 = tbl[0].a; b4 = tbl[0].b; in_valid4 = tbl[0].v;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("table[%0d]", i), obs4(),
            {4'b0000, tbl[i].r, tbl[i].bo, tbl[i].ov, tbl[i].z, tbl[i].ng, tbl[i].vo});
      if (i < 8) begin
        a4 = tbl[i+1].a; b4 = tbl[i+1].b; in_valid4 = tbl[i+1].v;
      end else begin
        in_valid4 = 1'b0;
      end
    end

    // Asynchronous reset between edges while out_valid=1, with an op in flight.
    a4 = 4'b0011; b4 = 4'b0001; in_valid4 = 1'b1;
    @(negedge clk);
    check("pre_async_rst", obs4(), {4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    a4 = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_immediate", obs4(), RST_STATE);
    @(negedge clk);
    check("async_rst_held", obs4(), RST_STATE);
    rst_n     = 1'b1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("post_rst_no_capture", obs4(), RST_STATE);

    // N=8 corner: 0x00 - 0x01.
    a8 = 8'h00; b8 = 8'h01; in_valid8 = 1'b1;
    @(negedge clk);
    check("n8_zero_minus_one", obs8(), {8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    // N=8 most-negative minus one.
    a8 = 8'h80; b8 = 8'h01;
    @(negedge clk);
    check("n8_minneg_minus_one", obs8(), {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    in_valid8 = 1'b0;
    @(negedge clk);
    check("n8_idle_hold", obs8(), {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    // Randomized phase against the reference model, both widths.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mdl4 = RST_STATE;
    mdl8 = RST_STATE;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("rand4", obs4(), mdl4);
        check("rand8", obs8(), mdl8);
      end
      a4        = 4'($urandom_range(0, 15));
      b4        = 4'($urandom_range(0, 15));
      in_valid4 = ($urandom_range(0, 3) != 0);
      a8        = 8'($urandom_range(0, 255));
      b8        = 8'($urandom_range(0, 255));
      in_valid8 = ($urandom_range(0, 3) != 0);
      if (in_valid4) mdl4 = model(4, int'(a4), int'(b4));
      else           mdl4[0] = 1'b0;
      if (in_valid8) mdl8 = model(8, int'(a8), int'(b8));
      else           mdl8[0] = 1'b0;
    end
    @(negedge clk);
    check("rand4_last", obs4(), mdl4);
    check("rand8_last", obs8(), mdl8);

    // Model sanity on the N=8 spec example, compared against the DUT path.
    in_valid8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    nxt = model(8, 0, 1);
    @(negedge clk);
    check("n8_model_example", obs8(), nxt);
    in_valid8 = 1'b0;
    in_valid4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
